// File: rtl/switch_debouncer.sv
// Per-switch debounce and edge detect: a channel accepts a new level once it has
// differed from the stable level on DEBOUNCE_CYCLES consecutive clocks.
module switch_debouncer #(
   parameter int NUM_SWITCHES    = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_SWITCHES-1:0] i_switches,
   output logic [NUM_SWITCHES-1:0] o_switches,
   output logic [NUM_SWITCHES-1:0] o_pressed,
   output logic [NUM_SWITCHES-1:0] o_released
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SWITCHES-1:0] stable_q,   stable_d;
   logic [NUM_SWITCHES-1:0] pressed_q,  pressed_d;
   logic [NUM_SWITCHES-1:0] released_q, released_d;
   logic [CNT_WIDTH-1:0]    cnt_q [NUM_SWITCHES];
   logic [CNT_WIDTH-1:0]    cnt_d [NUM_SWITCHES];

   // Per-channel next state: any sample matching the stable level clears the window.
   always_comb begin
      stable_d   = stable_q;
      pressed_d  = '0;
      released_d = '0;
      for (int k = 0; k < NUM_SWITCHES; k++) begin
         cnt_d[k] = cnt_q[k];
      end
      for (int k = 0; k < NUM_SWITCHES; k++) begin
         if (i_switches[k] == stable_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == CNT_LAST) begin
            stable_d[k]   = i_switches[k];
            cnt_d[k]      = '0;
            pressed_d[k]  = i_switches[k];
            released_d[k] = ~i_switches[k];
         end else begin
            cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stable_q   <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         for (int k = 0; k < NUM_SWITCHES; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         stable_q   <= stable_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         for (int k = 0; k < NUM_SWITCHES; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign o_switches = stable_q;
   assign o_pressed  = pressed_q;
   assign o_released = released_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: two debouncers (window 4 and window 1) checked against a
// sample-history reference model.
module tb_switch_debouncer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw4_i = 4'b0000;
   logic [3:0] sw1_i = 4'b0000;
   logic [3:0] sw4_o, p4_o, r4_o;
   logic [3:0] sw1_o, p1_o, r1_o;

   int total = 0;
   int bad   = 0;

   logic [23:0] exp_q [$];

   logic [3:0] m_s [2];
   logic [3:0] m_p [2];
   logic [3:0] m_r [2];
   bit         hist [2][4][$];

   always #5 clk = ~clk;

   switch_debouncer #(.NUM_SWITCHES(4), .DEBOUNCE_CYCLES(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_switches(sw4_i),
      .o_switches(sw4_o), .o_pressed(p4_o), .o_released(r4_o)
   );

   switch_debouncer #(.NUM_SWITCHES(4), .DEBOUNCE_CYCLES(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_switches(sw1_i),
      .o_switches(sw1_o), .o_pressed(p1_o), .o_released(r1_o)
   );

   // Reference: a level is accepted when the last d samples since reset all differ from it.
   task automatic model(input int inst, input int d, input logic [3:0] in, input logic r);
      bit all_diff;
      m_p[inst] = 4'b0000;
      m_r[inst] = 4'b0000;
      if (!r) begin
         m_s[inst] = 4'b0000;
         for (int ch = 0; ch < 4; ch++) hist[inst][ch].delete();
      end else begin
         for (int ch = 0; ch < 4; ch++) begin
            hist[inst][ch].push_back(in[ch]);
            if (hist[inst][ch].size() > d) void'(hist[inst][ch].pop_front());
            if (hist[inst][ch].size() == d) begin
               all_diff = 1'b1;
               for (int j = 0; j < d; j++)
                  if (hist[inst][ch][j] == m_s[inst][ch]) all_diff = 1'b0;
               if (all_diff) begin
                  m_s[inst][ch] = in[ch];
                  m_p[inst][ch] = in[ch];
                  m_r[inst][ch] = ~in[ch];
               end
            end
         end
      end
   endtask

   task automatic step(input logic [3:0] a4, input logic [3:0] a1, input logic r);
      @(negedge clk);
      sw4_i = a4;
      sw1_i = a1;
      rst_n = r;
      model(0, 4, a4, r);
      model(1, 1, a1, r);
      exp_q.push_back({m_s[0], m_p[0], m_r[0], m_s[1], m_p[1], m_r[1]});
   endtask

   // Monitor: compare registered outputs after every edge that has a pending expectation.
   initial begin
      logic [23:0] exp_v, got_v;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {sw4_o, p4_o, r4_o, sw1_o, p1_o, r1_o};
            total++;
            if (got_v !== exp_v) begin
               bad++;
               $display("FAIL outputs t=%0t got=%h expected=%h (sw4,p4,r4,sw1,p1,r1)",
                        $time, got_v, exp_v);
            end
         end
      end
   end

   initial begin
      logic [3:0] cur4, cur1, flip;
      int         waited;
      for (int i = 0; i < 2; i++) begin
         m_s[i] = 4'b0000; m_p[i] = 4'b0000; m_r[i] = 4'b0000;
      end

      repeat (3) step(4'b0000, 4'b0000, 1'b0);
      repeat (20) step(4'b0000, 4'b0000, 1'b1);

      // Channel 0 press; window-1 channel 3 toggles on successive edges.
      step(4'b0001, 4'b1000, 1'b1);
      step(4'b0001, 4'b0000, 1'b1);
      repeat (6) step(4'b0001, 4'b0000, 1'b1);

      // Channel 1 glitch of three samples, then back.
      repeat (3) step(4'b0011, 4'b0000, 1'b1);
      repeat (6) step(4'b0001, 4'b0000, 1'b1);

      // Simultaneous change on all channels.
      repeat (6) step(4'b1110, 4'b1111, 1'b1);

      // Channel 2 at count 2, then asynchronous reset between edges.
      repeat (2) step(4'b1010, 4'b1111, 1'b1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({sw4_o, p4_o, r4_o, sw1_o, p1_o, r1_o} !== 24'h000000) begin
         bad++;
         $display("FAIL async_reset got=%h expected=000000",
                  {sw4_o, p4_o, r4_o, sw1_o, p1_o, r1_o});
      end
      repeat (2) step(4'b0100, 4'b0000, 1'b0);
      repeat (6) step(4'b0100, 4'b0000, 1'b1);

      // Randomized phase with occasional reset.
      cur4 = 4'b0100;
      for (int i = 0; i < 400; i++) begin
         for (int ch = 0; ch < 4; ch++) flip[ch] = ($urandom_range(0, 5) == 0);
         cur4 = cur4 ^ flip;
         cur1 = 4'($urandom);
         step(cur4, cur1, ($urandom_range(0, 99) != 0));
      end
      repeat (4) step(cur4, cur1, 1'b1);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
